// File: rtl/random_pkg.sv
// Shared types and constants for the random roller: FSM states, default LFSR
// taps/seed, and the width rule for the interval and wait counters.
package random_pkg;

    typedef enum logic [0:0] {S_IDLE, S_ROLL} state_t;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Sized to hold the longest interval of a roll.
    function automatic int unsigned interval_width(input int unsigned base,
                                                   input int unsigned inc,
                                                   input int unsigned n_steps);
        return $clog2(base + inc * (n_steps - 1) + 1);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR with a seed load that maps a zero seed
// onto SEED, so the register can never lock up at zero.
module lfsr_galois
    import random_pkg::*;
#(
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        if (i_load) begin
            state_d = (i_load_val == '0) ? SEED : i_load_val;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/random_roller.sv
// Decelerating dice roll: a start pulse launches N_STEPS display updates at
// steadily growing intervals, ending with a one-cycle done pulse.
module random_roller
    import random_pkg::*;
#(
    parameter int unsigned       WIDTH         = 4,
    parameter int unsigned       LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] TAPS          = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED,
    parameter int unsigned       N_STEPS       = 8,
    parameter int unsigned       BASE_INTERVAL = 2,
    parameter int unsigned       INTERVAL_INC  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_seed_load,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [WIDTH-1:0]  o_random_out,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned CNT_W  = interval_width(BASE_INTERVAL, INTERVAL_INC, N_STEPS);
    localparam int unsigned STEP_W = $clog2(N_STEPS + 1);
    localparam logic [WIDTH-1:0] CAND_FLIP = WIDTH'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   interval_q, interval_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic [LFSR_W-1:0]  lfsr_state;
    logic [WIDTH-1:0]   cand;
    logic [WIDTH-1:0]   cand_sel;
    logic               seed_load;
    logic               update;
    logic               last;

    assign seed_load = i_seed_load && (state_q == S_IDLE);

    lfsr_galois #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (seed_load),
        .i_load_val (i_seed),
        .o_state    (lfsr_state)
    );

    // Flip the lsb on a repeat so the display visibly changes on every update.
    assign cand     = WIDTH'(lfsr_state);
    assign cand_sel = (cand == out_q) ? (cand ^ CAND_FLIP) : cand;

    assign update = i_stop || (wait_q == interval_q - CNT_W'(1));
    assign last   = i_stop || (step_q == STEP_W'(N_STEPS - 1));

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        done_d     = 1'b0;
        wait_d     = wait_q;
        interval_d = interval_q;
        step_d     = step_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_ROLL;
                    wait_d     = '0;
                    step_d     = '0;
                    interval_d = CNT_W'(BASE_INTERVAL);
                end
            end
            S_ROLL: begin
                if (update) begin
                    out_d      = cand_sel;
                    wait_d     = '0;
                    step_d     = step_q + STEP_W'(1);
                    interval_d = interval_q + CNT_W'(INTERVAL_INC);
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            out_q      <= '0;
            done_q     <= 1'b0;
            wait_q     <= '0;
            interval_q <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            done_q     <= done_d;
            wait_q     <= wait_d;
            interval_q <= interval_d;
            step_q     <= step_d;
        end
    end

    assign o_random_out = out_q;
    assign o_busy       = (state_q == S_ROLL);
    assign o_done       = done_q;

endmodule

// File: doc/random_roller.md
Name: random_roller

Overview:
- Parametrised successor to the lab1 4-bit random-output FSM: a Galois LFSR free-runs every cycle, and a start pulse launches a decelerating "roll".
- During the roll the displayed value updates at progressively longer intervals, then settles on a final value and signals done.
- Sits between the key/debounce front end and the seven-segment display decoder.

Parameters:
- WIDTH, 4, output value width in bits.
- LFSR_W, 16, LFSR width; must be >= WIDTH.
- TAPS, 16'hB400, Galois feedback mask (LFSR_W bits).
- SEED, 16'hACE1, reset seed, and replacement for any zero seed load; must be nonzero.
- N_STEPS, 8, number of displayed updates per roll; must be >= 1.
- BASE_INTERVAL, 2, cycles before the first update; must be >= 1.
- INTERVAL_INC, 1, cycles added to the interval after each update.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  single-cycle pulse that starts a roll; sampled only in IDLE.
- i_stop  input  1  single-cycle pulse that forces early settle; sampled only in ROLL.
- i_seed_load  input  1  loads i_seed into the LFSR; honoured only in IDLE.
- i_seed  input  LFSR_W  seed value.
- o_random_out  output  WIDTH  displayed value.
- o_busy  output  1  high while in ROLL.
- o_done  output  1  one-cycle pulse, coincident with the final value appearing.

Behaviour:
- Reset (async, i_rst=1):
  - lfsr=SEED, o_random_out=0, state=IDLE, o_busy=0, o_done=0.
  - All counters cleared.
  - Reset asserted mid-roll aborts the roll immediately; there is no done pulse.
- LFSR:
  - Galois right-shift every cycle in every state: lsb=lfsr[0]; lfsr=(lfsr>>1) ^ (lsb ? TAPS : 0).
  - Never zero by construction.
  - Seed load: if i_seed==0, load SEED, else load i_seed. The load replaces the shift for that cycle.
- Candidate value:
  - cand = lfsr[WIDTH-1:0] taken from the registered LFSR.
  - If cand == o_random_out, use cand ^ 1 instead, so consecutive displayed values always differ.
- States: IDLE, ROLL.
- IDLE:
  - i_start=1 -> ROLL next edge; wait_cnt=0, step_cnt=0, interval=BASE_INTERVAL, o_busy=1 from that edge.
  - o_random_out holds its value.
  - i_stop is ignored.
  - If i_start and i_seed_load arrive together: the seed load happens and the roll starts.
- ROLL:
  - Each cycle, wait_cnt increments.
  - When wait_cnt==interval-1 (update edge):
    - o_random_out <= candidate.
    - wait_cnt=0, step_cnt++, interval += INTERVAL_INC.
  - Start pulse sampled at edge t0 -> first update at edge t0+BASE_INTERVAL.
  - Update k (0-based) occurs interval BASE_INTERVAL+k*INTERVAL_INC cycles after update k-1.
  - Final update (step_cnt==N_STEPS-1):
    - o_done=1 for that one cycle.
    - -> IDLE, o_busy=0 at the same edge.
  - Total roll length = N_STEPS*BASE_INTERVAL + INTERVAL_INC*N_STEPS*(N_STEPS-1)/2 cycles; defaults give 44.
  - i_stop=1 -> next edge performs the final update (candidate rule applies), o_done pulse, -> IDLE, regardless of wait_cnt.
  - i_stop coinciding with a regular update edge produces exactly one update and done.
  - i_start is ignored; the roll is not restarted.
  - i_seed_load is ignored.
- Widths:
  - interval register and wait_cnt: $clog2(BASE_INTERVAL+INTERVAL_INC*(N_STEPS-1)+1) bits.
  - step_cnt: $clog2(N_STEPS+1) bits.
  - No wrap is possible within a roll.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package random_pkg:
  - state_t enum {S_IDLE, S_ROLL}.
  - Default constants for TAPS and SEED.
  - Function computing the interval/counter width.
- Sub-module lfsr_galois (parameters LFSR_W, TAPS, SEED):
  - Inputs: i_clk, i_rst, i_load, i_load_val.
  - Output: o_state.
  - Applies the zero-seed substitution internally.
- The top module holds the FSM, counters and candidate logic.

Test Plan:
- Reset mid-roll: assert i_rst 10 cycles after start -> o_random_out=0, o_busy=0, no o_done. After release, the first LFSR value equals one SEED shift.
- Default roll: start at edge t0 -> updates at t0+2, +5, +9, +14, +20, +27, +35, +44. o_done high only at t0+44. o_busy high over edges t0..t0+43. Every value matches the golden LFSR model.
- No-repeat rule: N_STEPS=8, force a seed so that cand equals the current output -> displayed value is cand^1, and no two consecutive displayed values are equal over 10000 rolls.
- Early stop: i_stop at t0+6 -> one update at t0+7, o_done at t0+7, IDLE at t0+7. A later i_stop in IDLE has no effect.
- Seed handling:
  - i_seed_load with i_seed=0 in IDLE -> lfsr==SEED next cycle.
  - i_seed_load with 16'h1234 -> lfsr==16'h1234.
  - i_seed_load during ROLL is ignored and the LFSR keeps shifting.
- Ignored start: a second i_start at t0+3 -> roll timing is unchanged (final update at t0+44). Then N_STEPS=1, BASE_INTERVAL=1 -> single update and o_done at t0+1.
